sync_lock_ctrl: RTL

Lock supervisor for the header-alignment seeker in the 64b/66b receive path. It sequences the seeker through restart and search, then latches the found bit offset. While locked it monitors header quality at that offset and declares loss-of-lock on excessive errors. After a loss-of-lock it re-runs the search. It sits between the seeker and the downstream frame aligner and gates data acceptance with `data_en_o`.

---
 rtl/sync_lock_ctrl_if.sv | 28 ++
 rtl/sync_lock_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sync_lock_ctrl_if.sv
// Seeker-side and aligner-side signals of the sync lock supervisor.
// slave: the supervisor itself; master: whatever drives it (datapath/seeker).
interface sync_lock_ctrl_if;
  logic       enable_i;
  logic       buffer_dv_i;
  logic [1:0] hdr_i;
  logic       seeker_synced_i;
  logic [6:0] seeker_offset_i;
  logic       seeker_rst_o;
  logic [6:0] offset_o;
  logic       locked_o;
  logic       data_en_o;
  logic       lock_loss_o;
  logic [7:0] relock_cnt_o;
  logic [1:0] state_o;

  modport slave (
    input  enable_i, buffer_dv_i, hdr_i, seeker_synced_i, seeker_offset_i,
    output seeker_rst_o, offset_o, locked_o, data_en_o, lock_loss_o,
           relock_cnt_o, state_o
  );

  modport master (
    output enable_i, buffer_dv_i, hdr_i, seeker_synced_i, seeker_offset_i,
    input  seeker_rst_o, offset_o, locked_o, data_en_o, lock_loss_o,
           relock_cnt_o, state_o
  );
endinterface

// File: rtl/sync_lock_ctrl.sv
// Lock supervisor for the 64b/66b header-alignment seeker: restart, search, lock, monitor.
// Define SYNC_LOCK_CTRL_TIMEOUT_EN to enable the SEARCH timeout (otherwise SEARCH waits forever).
//
// state   | meaning
// IDLE    | disabled, seeker held in reset
// RESTART | seeker held in reset for LOCK_HOLD cycles
// SEARCH  | seeker running, waiting for sync (optionally with timeout)
// LOCKED  | offset latched, header quality monitored per window
module sync_lock_ctrl #(
  parameter int unsigned LOCK_HOLD = 4,
  parameter int unsigned ERR_WIN   = 64,
  parameter int unsigned ERR_MAX   = 4,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sync_lock_ctrl_if.slave   bus
);
  localparam int unsigned HW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam int unsigned WW = (ERR_WIN   > 1) ? $clog2(ERR_WIN)   : 1;
  localparam int unsigned EW = (ERR_MAX   > 1) ? $clog2(ERR_MAX)   : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    SEARCH  = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [WW-1:0]  win_q, win_d;
  logic [EW-1:0]  err_q, err_d;
  logic [6:0]     offset_q, offset_d;
  logic [7:0]     relock_q, relock_d;
  logic           seeker_rst_q, seeker_rst_d;
  logic           locked_q, locked_d;
  logic           data_en_q, data_en_d;
  logic           loss_q, loss_d;
  logic           hdr_bad;
  logic           timeout_hit;

`ifdef SYNC_LOCK_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0]  to_q, to_d;
  assign timeout_hit = bus.buffer_dv_i && (to_q == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign hdr_bad = (bus.hdr_i == 2'b00) || (bus.hdr_i == 2'b11);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    win_d     = win_q;
    err_d     = err_q;
    offset_d  = offset_q;
    relock_d  = relock_q;
    loss_d    = 1'b0;
    data_en_d = locked_q & bus.buffer_dv_i;
`ifdef SYNC_LOCK_CTRL_TIMEOUT_EN
    to_d      = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          state_d = RESTART;
          hold_d  = '0;
        end
      end
      RESTART: begin
        if (hold_q == HW'(LOCK_HOLD - 1)) begin
          state_d = SEARCH;
`ifdef SYNC_LOCK_CTRL_TIMEOUT_EN
          to_d    = '0;
`endif
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      SEARCH: begin
`ifdef SYNC_LOCK_CTRL_TIMEOUT_EN
        if (bus.buffer_dv_i) to_d = to_q + 1'b1;
`endif
        // sync takes priority over a coincident timeout
        if (bus.seeker_synced_i) begin
          state_d  = LOCKED;
          offset_d = bus.seeker_offset_i;
          win_d    = '0;
          err_d    = '0;
        end else if (timeout_hit) begin
          state_d = RESTART;
          hold_d  = '0;
        end
      end
      LOCKED: begin
        if (bus.buffer_dv_i) begin
          if (hdr_bad && (err_q == EW'(ERR_MAX - 1))) begin
            loss_d   = 1'b1;
            relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 1'b1;
            state_d  = RESTART;
            hold_d   = '0;
          end else if (win_q == WW'(ERR_WIN - 1)) begin
            win_d = '0;
            err_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            err_d = err_q + EW'(hdr_bad);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.enable_i) begin
      state_d  = IDLE;
      loss_d   = 1'b0;
      relock_d = relock_q;
      offset_d = offset_q;
    end
    seeker_rst_d = (state_d == IDLE) || (state_d == RESTART);
    locked_d     = (state_d == LOCKED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      win_q        <= '0;
      err_q        <= '0;
      offset_q     <= '0;
      relock_q     <= '0;
      seeker_rst_q <= 1'b1;
      locked_q     <= 1'b0;
      data_en_q    <= 1'b0;
      loss_q       <= 1'b0;
`ifdef SYNC_LOCK_CTRL_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      win_q        <= win_d;
      err_q        <= err_d;
      offset_q     <= offset_d;
      relock_q     <= relock_d;
      seeker_rst_q <= seeker_rst_d;
      locked_q     <= locked_d;
      data_en_q    <= data_en_d;
      loss_q       <= loss_d;
`ifdef SYNC_LOCK_CTRL_TIMEOUT_EN
      to_q         <= to_d;
`endif
    end
  end

  assign bus.seeker_rst_o = seeker_rst_q;
  assign bus.offset_o     = offset_q;
  assign bus.locked_o     = locked_q;
  assign bus.data_en_o    = data_en_q;
  assign bus.lock_loss_o  = loss_q;
  assign bus.relock_cnt_o = relock_q;
  assign bus.state_o      = state_q;
endmodule
